uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Boot-time program loader upstream of the pipelined core: receives an image over UART 8N1,
//  packs it little-endian into 32-bit words, writes it into BRAM port A, holds core in reset.
//  Releases core_rst_n only after a complete, valid image. BRAM port A is muxed to this block while core_rst_n=0.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  BAUD         115200       UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide)
//  BASE_ADDR    32'h0        byte address of first image byte (word aligned)
//  MAX_BYTES    65536        largest accepted image length in bytes
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous, active-low reset
//  rx          in   1   UART receive line, idle high, asynchronous to clk
//  mem_we      out  4   BRAM byte-lane write enables (lane i = bits 8i+7:8i)
//  mem_addr    out  32  BRAM byte address, always word aligned
//  mem_wdata   out  32  BRAM write data
//  core_rst_n  out  1   active-low reset to core; 1 only in DONE
//  busy        out  1   load in progress
//  done        out  1   image loaded, sticky until rst_n
//  error       out  1   load failed, sticky until rst_n
// BEHAVIOUR
//  Reset: all outputs 0 (core_rst_n=0); FSM=LEN, counters/accumulators cleared.
//  rx passes a 2-flop synchroniser before use.
//  UART RX: falling edge starts bit timer; start bit re-sampled at CLKS_PER_BIT/2, high -> glitch, back to idle,
//   no byte. Data bits sampled LSB first at bit centres. Stop bit sampled at centre: 1 -> byte_valid pulse
//   (1 cycle); 0 -> frame_err pulse. Receiver re-arms at stop-bit centre.
//  Frame: 4 length bytes N (LE, in bytes), N payload bytes, [checksum byte, see CONFIGURATION].
//  FSM: LEN -> DATA -> DONE; any state -> ERROR on frame_err (except DONE/ERROR, which are terminal).
//   LEN: collect 4 bytes; busy=1 from first byte. After 4th: N==0 -> DONE next cycle;
//    N>MAX_BYTES -> ERROR; else DATA.
//   DATA: byte k (0..N-1) goes to lane k[1:0] of word accumulator. Word write issued the cycle after
//    lane-3 byte or after byte N-1: mem_we = mask of lanes filled (4'b1111 for full word), mem_addr =
//    BASE_ADDR + (k & ~3), mem_wdata = accumulator (unfilled lanes 0). mem_we high exactly 1 cycle;
//    mem_addr/mem_wdata hold last value otherwise. Accumulator cleared after each write.
//   DONE: core_rst_n=1, done=1, busy=0; further rx bytes ignored, no writes.
//   ERROR: error=1, busy=0, core_rst_n=0, mem_we=0; further bytes ignored.
//  Latency: write strobe 1 cycle after final byte_valid; DONE entered the cycle after last write.
//  Byte spacing >=10*CLKS_PER_BIT cycles, so write strobe never collides with next byte.
//  Address arithmetic 32-bit, wraps modulo 2^32 (no saturation); byte counter width clog2(MAX_BYTES+1).
//  rst_n mid-load: immediate abort to reset state; partial image in BRAM is not cleared.
// CONFIGURATION
//  UART_LOADER_CHECKSUM_EN defined: after payload one extra byte = (sum of payload bytes) mod 256.
//   State CSUM follows DATA (or LEN when N==0); match -> DONE, mismatch -> ERROR. Last data write still
//   issued before checksum compared. Not defined: no CSUM state; DATA -> DONE directly.
// STRUCTURE
//  Shared package loader_pkg: FSM state encoding (LEN, DATA, CSUM, DONE, ERROR), clks_per_bit() function,
//   LEN_BYTES=4 constant.
//  One sub-module: uart_rx (sync + bit timer + shift reg; outputs byte[7:0], byte_valid, frame_err).
//  Top holds FSM, length/byte counters, word accumulator, checksum, write port.
// TESTING
//  Reset then idle rx=1 for 1 ms -> all outputs 0, no mem_we pulses.
//  N=8, bytes 11..88 -> two writes: addr 0 data 0x44332211 we F, addr 4 data 0x88776655 we F; done=1, core_rst_n=1.
//  N=5, bytes AA BB CC DD EE -> writes addr0 0xDDCCBBAA we F, addr4 0x000000EE we 1; then DONE.
//  N=0 -> no writes, DONE (with CHECKSUM_EN: needs byte 00; byte 01 -> ERROR).
//  Stop bit forced 0 on payload byte 3 -> error=1, core_rst_n stays 0, no further writes; N=MAX_BYTES+1 -> ERROR after 4th length byte.
//  CHECKSUM_EN, N=2 bytes 01 02 then 03 -> DONE; then 04 instead -> ERROR; 0.3-bit rx glitch -> no byte, no error.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings, frame constants, baud helper.
// Optional feature macro used across the bundle: UART_LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int LEN_BYTES = 4;

    function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// BRAM port-A write bus driven by the program loader while the core is held in reset.
interface uart_prog_loader_if;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_prog_loader_uart_rx.sv
// UART 8N1 receiver: 2-flop synchroniser, mid-bit sampling, start-bit glitch rejection.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s, rx_prev_q, fall;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tick_half, tick_full;

    assign rx_s      = sync_q[1];
    assign fall      = rx_prev_q & ~rx_s;
    assign tick_half = (cnt_q == CW'(HALF - 1));
    assign tick_full = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (fall) state_d = RX_START;
            RX_START: if (tick_half) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_full && bit_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (tick_full) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchroniser resets to the idle-high line level so reset release is not seen as a start edge.
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_data    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every flop samples pre-edge values.
            sync_q     <= {sync_q[0], rx};
            rx_prev_q  <= rx_s;
            state_q    <= state_d;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state_d != state_q || state_q == RX_IDLE || (state_q == RX_DATA && tick_full))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);

            if (state_q == RX_START)
                bit_q <= '0;

            if (state_q == RX_DATA && tick_full) begin
                shift_q <= {rx_s, shift_q[7:1]};
                bit_q   <= bit_q + 3'd1;
            end

            if (state_q == RX_STOP && tick_full) begin
                rx_data    <= shift_q;
                byte_valid <= rx_s;
                frame_err  <= ~rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: UART image -> little-endian 32-bit BRAM writes, core held in reset until image is complete.
// Optional trailing checksum byte enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 100_000_000,
    parameter int          BAUD        = 115200,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          MAX_BYTES   = 65536
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    uart_prog_loader_if.master   mem,
    output logic                 core_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int BCW = $clog2(MAX_BYTES + 1);

    logic [7:0]    rx_data;
    logic          byte_valid, frame_err;

    loader_state_e state_q, state_d;
    logic [31:0]   len_q;
    logic [1:0]    len_cnt_q;
    logic          started_q;
    logic [BCW-1:0] byte_cnt_q;
    logic [31:0]   acc_q;
    logic [3:0]    lane_mask_q;
    logic          fin_q;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic [31:0]   len_full;
    logic          len_last;
    logic [31:0]   byte_idx;
    logic          last_byte;
    logic [1:0]    lane;
    logic [31:0]   acc_next;
    logic [3:0]    mask_next;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign len_full  = {rx_data, len_q[23:0]};
    assign len_last  = (len_cnt_q == 2'(LEN_BYTES - 1));
    assign byte_idx  = 32'(byte_cnt_q);
    assign last_byte = (byte_idx == len_q - 32'd1);
    assign lane      = byte_cnt_q[1:0];
    assign acc_next  = acc_q | (32'(rx_data) << {lane, 3'b000});
    assign mask_next = lane_mask_q | (4'b0001 << lane);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN: begin
                if (frame_err)
                    state_d = ST_ERROR;
                else if (byte_valid && len_last) begin
                    if (len_full == 32'd0)
`ifdef UART_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    else if (len_full > 32'(MAX_BYTES))
                        state_d = ST_ERROR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // fin_q is high the cycle the final write strobe is on the bus.
                if (frame_err)
                    state_d = ST_ERROR;
                else if (fin_q)
`ifdef UART_LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
            end
`ifdef UART_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (frame_err)
                    state_d = ST_ERROR;
                else if (byte_valid)
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LEN;
            len_q         <= '0;
            len_cnt_q     <= '0;
            started_q     <= 1'b0;
            byte_cnt_q    <= '0;
            acc_q         <= '0;
            lane_mask_q   <= '0;
            fin_q         <= 1'b0;
            mem.mem_we    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mem.mem_we <= '0;
            fin_q      <= 1'b0;

            if (byte_valid) begin
                case (state_q)
                    ST_LEN: begin
                        len_q[{len_cnt_q, 3'b000} +: 8] <= rx_data;
                        len_cnt_q <= len_cnt_q + 2'd1;
                        started_q <= 1'b1;
                    end
                    ST_DATA: begin
                        byte_cnt_q <= byte_cnt_q + BCW'(1);
`ifdef UART_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q + rx_data;
`endif
                        if (lane == 2'd3 || last_byte) begin
                            mem.mem_we    <= mask_next;
                            mem.mem_addr  <= BASE_ADDR + (byte_idx & ~32'd3);
                            mem.mem_wdata <= acc_next;
                            acc_q         <= '0;
                            lane_mask_q   <= '0;
                            fin_q         <= last_byte;
                        end else begin
                            acc_q       <= acc_next;
                            lane_mask_q <= mask_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign core_rst_n = (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);
    assign busy       = (state_q == ST_LEN && started_q) || state_q == ST_DATA || state_q == ST_CSUM;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader; the checksum scenarios run when UART_LOADER_CHECKSUM_EN is defined.
module tb_uart_prog_loader;

    localparam int CLK_FREQ_HZ = 1_600_000;
    localparam int BAUD        = 100_000;
    localparam int CPB         = CLK_FREQ_HZ / BAUD;
    localparam int MAX_BYTES   = 64;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic core_rst_n, busy, done, error;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    wr_t mon_exp;

    uart_prog_loader_if bus ();

    uart_prog_loader #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .BASE_ADDR   (32'h0),
        .MAX_BYTES   (MAX_BYTES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .mem        (bus.master),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Every write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we !== 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got we=%b addr=%h data=%h", bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.mem_we !== mon_exp.we || bus.mem_addr !== mon_exp.addr || bus.mem_wdata !== mon_exp.data) begin
                    errors++;
                    $display("FAIL write got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                             bus.mem_we, bus.mem_addr, bus.mem_wdata, mon_exp.we, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rx = 1'b1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Pushes the expected writes for a payload, then transmits length, payload and (if enabled) checksum.
    task automatic send_frame(input logic [7:0] pay[$], input logic [7:0] csum_delta);
        int          n;
        logic [31:0] len;
        logic [31:0] acc;
        logic [3:0]  mask;
        logic [7:0]  sum;
        wr_t         w;
        n = pay.size();
        len = 32'(n);
        acc = '0;
        mask = '0;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            acc  = acc | (32'(pay[k]) << (8 * (k % 4)));
            mask = mask | (4'b0001 << (k % 4));
            sum  = sum + pay[k];
            if (k % 4 == 3 || k == n - 1) begin
                w.we = mask;
                w.addr = 32'(k) & ~32'd3;
                w.data = acc;
                exp_q.push_back(w);
                acc = '0;
                mask = '0;
            end
        end
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
        for (int k = 0; k < n; k++) send_byte(pay[k], 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(sum + csum_delta, 1'b1);
`endif
    endtask

    task automatic wait_end(input string name);
        checks++;
        for (int i = 0; i < 40 * CPB; i++) begin
            if (done || error) break;
            @(negedge clk);
        end
        if (!(done || error)) begin
            errors++;
            $display("FAIL %s_timeout got done=%b error=%b expected done or error", name, done, error);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({core_rst_n, busy, done, error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status got %b expected 0000", {core_rst_n, busy, done, error});
        end
        checks++;
        if (bus.mem_we !== 4'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got we=%b addr=%h data=%h expected zeros", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        // 1 ms of idle line at the bench clock rate.
        repeat (CLK_FREQ_HZ / 1000) @(negedge clk);
        checks++;
        if ({core_rst_n, busy, done, error} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_status got %b expected 0000", {core_rst_n, busy, done, error});
        end
    endtask

    task automatic test_n8();
        logic [7:0] p[$];
        do_reset();
        for (int i = 0; i < 8; i++) p.push_back(8'((i + 1) * 8'h11));
        send_frame(p, 8'h00);
        wait_end("n8");
        checks++;
        if ({core_rst_n, busy, done, error} !== 4'b1010) begin
            errors++;
            $display("FAIL n8_status got %b expected 1010", {core_rst_n, busy, done, error});
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL n8_writes_pending got %0d expected 0", exp_q.size());
        end
        send_byte(8'h5A, 1'b1);
        checks++;
        if ({core_rst_n, done, error} !== 3'b110) begin
            errors++;
            $display("FAIL done_sticky got %b expected 110", {core_rst_n, done, error});
        end
    endtask

    task automatic test_n5();
        logic [7:0] p[$];
        do_reset();
        for (int i = 0; i < 5; i++) p.push_back(8'(8'hAA + i * 8'h11));
        send_frame(p, 8'h00);
        wait_end("n5");
        checks++;
        if ({core_rst_n, busy, done, error} !== 4'b1010) begin
            errors++;
            $display("FAIL n5_status got %b expected 1010", {core_rst_n, busy, done, error});
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL n5_writes_pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd8 : 8'd0, 1'b1);
        for (int k = 0; k < 8; k++) send_byte(8'(8'h10 + k), (k == 3) ? 1'b0 : 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({core_rst_n, busy, done, error} !== 4'b0001) begin
            errors++;
            $display("FAIL frame_err_status got %b expected 0001", {core_rst_n, busy, done, error});
        end
    endtask

    task automatic test_oversize();
        logic [31:0] len;
        do_reset();
        len = 32'(MAX_BYTES + 1);
        for (int i = 0; i < 3; i++) send_byte(len[8*i +: 8], 1'b1);
        checks++;
        if ({busy, error} !== 2'b10) begin
            errors++;
            $display("FAIL oversize_partial got busy,error=%b expected 10", {busy, error});
        end
        send_byte(len[31:24], 1'b1);
        checks++;
        if ({core_rst_n, busy, done, error} !== 4'b0001) begin
            errors++;
            $display("FAIL oversize_status got %b expected 0001", {core_rst_n, busy, done, error});
        end
    endtask

    task automatic test_glitch_then_n0();
        logic [7:0] p[$];
        do_reset();
        rx = 1'b0;
        repeat (CPB * 3 / 10) @(negedge clk);
        rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        checks++;
        if ({busy, done, error} !== 3'b000) begin
            errors++;
            $display("FAIL glitch_status got %b expected 000", {busy, done, error});
        end
        send_frame(p, 8'h00);
        wait_end("n0");
        checks++;
        if ({core_rst_n, busy, done, error} !== 4'b1010) begin
            errors++;
            $display("FAIL n0_status got %b expected 1010", {core_rst_n, busy, done, error});
        end
    endtask

    task automatic test_abort();
        do_reset();
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({core_rst_n, busy, done, error} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_status got %b expected 0000", {core_rst_n, busy, done, error});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef UART_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] p[$];
        p.push_back(8'h01);
        p.push_back(8'h02);
        do_reset();
        send_frame(p, 8'h00);
        wait_end("csum_ok");
        checks++;
        if ({core_rst_n, done, error} !== 3'b110 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL csum_ok got %b pending=%0d expected 110 pending=0", {core_rst_n, done, error}, exp_q.size());
        end
        do_reset();
        send_frame(p, 8'h01);
        wait_end("csum_bad");
        checks++;
        if ({core_rst_n, done, error} !== 3'b001 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL csum_bad got %b pending=%0d expected 001 pending=0", {core_rst_n, done, error}, exp_q.size());
        end
        p.delete();
        do_reset();
        send_frame(p, 8'h01);
        wait_end("csum_n0_bad");
        checks++;
        if ({core_rst_n, done, error} !== 3'b001) begin
            errors++;
            $display("FAIL csum_n0_bad got %b expected 001", {core_rst_n, done, error});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_n8();
        test_n5();
        test_frame_err();
        test_oversize();
        test_glitch_then_n0();
        test_abort();
`ifdef UART_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
